// File: rtl/alu_arith_cmp.sv
// Registered arithmetic/compare slice of the CPU ALU: add/sub with Z/V/N flags
// and set-on-compare results, one cycle of latency.
module alu_arith_cmp #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    input  logic [5:0]       ALUFun,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             out_valid
);

    localparam int unsigned Msb = WIDTH - 1;

    logic             is_arith;
    logic             is_cmp;
    logic             do_sub;
    logic [2:0]       cmp_code;
    logic             zero_b;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf_s;
    logic             cmp_bit;

    logic [WIDTH-1:0] s_d, s_q;
    logic             z_d, z_q;
    logic             v_d, v_q;
    logic             n_d, n_q;
    logic             valid_q;

    always_comb begin
        is_arith = (ALUFun[5:4] == 2'b00);
        is_cmp   = (ALUFun[5:4] == 2'b11);
        cmp_code = ALUFun[3:1];
        // Everything except an explicit add subtracts, so flags are always meaningful.
        do_sub   = ~is_arith | ALUFun[0];
        zero_b   = is_cmp & ((cmp_code == 3'b110) | (cmp_code == 3'b101) |
                             (cmp_code == 3'b111));
        b_eff    = zero_b ? '0 : B;
        b_op     = do_sub ? ~b_eff : b_eff;
        sum      = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, do_sub};
        res      = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        // b_op is already inverted for subtract, so one add-style rule covers both.
        ovf_s    = (A[Msb] == b_op[Msb]) & (res[Msb] != A[Msb]);

        z_d = (res == '0);
        if (Sign) begin
            v_d = ovf_s;
            n_d = res[Msb] ^ ovf_s;
        end else begin
            v_d = do_sub ? ~carry : carry;
            n_d = do_sub & ~carry;
        end

        cmp_bit = 1'b0;
        case (cmp_code)
            3'b001:  cmp_bit = z_d;
            3'b000:  cmp_bit = ~z_d;
            3'b010:  cmp_bit = n_d;
            3'b110:  cmp_bit = n_d | z_d;
            3'b101:  cmp_bit = n_d;
            3'b111:  cmp_bit = ~n_d & ~z_d;
            default: cmp_bit = 1'b0;
        endcase

        if (is_arith) begin
            s_d = res;
        end else if (is_cmp) begin
            s_d = {{(WIDTH-1){1'b0}}, cmp_bit};
        end else begin
            s_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q <= s_d;
                z_q <= z_d;
                v_q <= v_d;
                n_q <= n_d;
            end
        end
    end

    assign S         = s_q;
    assign Z         = z_q;
    assign V         = v_q;
    assign N         = n_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_arith_cmp.sv
// Scoreboard bench for alu_arith_cmp: directed vectors with hand-derived results
// plus randomized ops checked against an exact-arithmetic reference model.
module tb_alu_arith_cmp;

    typedef struct packed {
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        n;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [5:0]  fun;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A, B;
    logic        Sign;
    logic [5:0]  ALUFun;
    logic [31:0] S;
    logic        Z, V, N, out_valid;

    int checks = 0;
    int errors = 0;
    res_t exp_q[$];
    vec_t tbl[$];
    res_t got, exp;
    res_t last;

    alu_arith_cmp #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Sign      (Sign),
        .ALUFun    (ALUFun),
        .S         (S),
        .Z         (Z),
        .V         (V),
        .N         (N),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic sign, logic [5:0] fun,
                                logic [31:0] s, logic z, logic v, logic n);
        vec_t t;
        t.a = a; t.b = b; t.sign = sign; t.fun = fun;
        t.exp = '{s: s, z: z, v: v, n: n};
        return t;
    endfunction

    // Reference model using exact 64-bit arithmetic on the interpreted operands.
    function automatic res_t model(logic [31:0] a, logic [31:0] b, logic sign, logic [5:0] fun);
        res_t   r;
        logic   arith, cmp, sub, bzero, cb;
        logic [31:0] be;
        logic [2:0]  code;
        longint x, y, e;
        longint max_s = 64'sd2147483647;
        longint min_s = -64'sd2147483648;
        longint max_u = 64'sd4294967295;
        arith = (fun[5:4] == 2'b00);
        cmp   = (fun[5:4] == 2'b11);
        code  = fun[3:1];
        sub   = !arith || fun[0];
        bzero = cmp && (code == 3'd6 || code == 3'd5 || code == 3'd7);
        be    = bzero ? 32'd0 : b;
        if (sign) begin
            x = longint'($signed(a));
            y = longint'($signed(be));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, be});
        end
        e = sub ? x - y : x + y;
        r.z = (e[31:0] == 32'd0);
        if (sign) begin
            r.v = (e > max_s) || (e < min_s);
            r.n = (e < 0);
        end else if (sub) begin
            r.v = (e < 0);
            r.n = (e < 0);
        end else begin
            r.v = (e > max_u);
            r.n = 1'b0;
        end
        case (code)
            3'd1:    cb = r.z;
            3'd0:    cb = !r.z;
            3'd2:    cb = r.n;
            3'd6:    cb = r.n || r.z;
            3'd5:    cb = r.n;
            3'd7:    cb = !r.n && !r.z;
            default: cb = 1'b0;
        endcase
        if (arith)    r.s = e[31:0];
        else if (cmp) r.s = {31'd0, cb};
        else          r.s = 32'd0;
        return r;
    endfunction

    // Drives one cycle of stimulus, records the expectation, and returns #1 after the edge.
    task automatic apply(logic valid, logic [31:0] a, logic [31:0] b, logic sign,
                         logic [5:0] fun, res_t e);
        in_valid = valid; A = a; B = b; Sign = sign; ALUFun = fun;
        if (valid && rst_n) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        apply(1'b1, 32'h1234, 32'h1, 1'b1, 6'b000000, '0);
        apply(1'b1, 32'h5678, 32'h2, 1'b0, 6'b000001, '0);
        checks++;
        if ({S, Z, V, N, out_valid} !== 36'd0) begin
            errors++;
            $display("FAIL reset: got S=%h Z=%b V=%b N=%b ov=%b, want all zero",
                     S, Z, V, N, out_valid);
        end
        rst_n = 1'b1;
        apply(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b1, 6'b000000, '{32'h7, 1'b0, 1'b0, 1'b0});
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL reset_release: out_valid=%b, want 1", out_valid);
        end else begin
            exp = exp_q.pop_front();
            got = '{S, Z, V, N};
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_release: got %h, want %h", got, exp);
            end
        end
    endtask

    task automatic run_table(string name);
        foreach (tbl[i]) begin
            apply(1'b1, tbl[i].a, tbl[i].b, tbl[i].sign, tbl[i].fun, tbl[i].exp);
            checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s[%0d]: out_valid=%b, want 1", name, i, out_valid);
            end else begin
                exp = exp_q.pop_front();
                got = '{S, Z, V, N};
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s[%0d]: got S=%h ZVN=%b%b%b, want S=%h ZVN=%b%b%b",
                             name, i, got.s, got.z, got.v, got.n, exp.s, exp.z, exp.v, exp.n);
                end
            end
        end
        tbl.delete();
    endtask

    task automatic test_signed_cmp;
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 1, 6'b000001, 32'h4C70F085, 0, 0, 0));
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 1, 6'b110011, 32'h0, 0, 0, 0));
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 1, 6'b110001, 32'h1, 0, 0, 0));
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 1, 6'b110101, 32'h0, 0, 0, 0));
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 1, 6'b111101, 32'h0, 0, 0, 0));
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 1, 6'b111011, 32'h0, 0, 0, 0));
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 1, 6'b111111, 32'h1, 0, 0, 0));
        run_table("signed_cmp");
    endtask

    task automatic test_inverted;
        tbl.push_back(mk(32'hFFFFFFF7, 32'h4C70F07C, 1, 6'b000001, 32'hB38F0F7B, 0, 0, 1));
        tbl.push_back(mk(32'hFFFFFFF7, 32'h4C70F07C, 1, 6'b110101, 32'h1, 0, 0, 1));
        tbl.push_back(mk(32'hFFFFFFF7, 32'h4C70F07C, 1, 6'b111101, 32'h1, 0, 0, 1));
        tbl.push_back(mk(32'hFFFFFFF7, 32'h4C70F07C, 1, 6'b111011, 32'h1, 0, 0, 1));
        tbl.push_back(mk(32'hFFFFFFF7, 32'h4C70F07C, 1, 6'b111111, 32'h0, 0, 0, 1));
        run_table("inverted");
    endtask

    task automatic test_unsigned;
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 0, 6'b110101, 32'h1, 0, 1, 1));
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 0, 6'b000001, 32'h4C70F085, 0, 1, 1));
        tbl.push_back(mk(32'h8, 32'hB38F0F83, 0, 6'b111011, 32'h0, 0, 0, 0));
        tbl.push_back(mk(32'hFFFFFFFF, 32'h1, 0, 6'b000000, 32'h0, 1, 1, 0));
        run_table("unsigned");
    endtask

    task automatic test_overflow_eq;
        tbl.push_back(mk(32'h7FFFFFFF, 32'h1, 1, 6'b000000, 32'h80000000, 0, 1, 0));
        tbl.push_back(mk(32'h80000000, 32'h1, 1, 6'b000001, 32'h7FFFFFFF, 0, 1, 1));
        tbl.push_back(mk(32'h12345678, 32'h12345678, 1, 6'b110011, 32'h1, 1, 0, 0));
        tbl.push_back(mk(32'h12345678, 32'h12345678, 1, 6'b110001, 32'h0, 1, 0, 0));
        tbl.push_back(mk(32'h5, 32'h5, 1, 6'b010000, 32'h0, 1, 0, 0));
        run_table("ovf_eq");
    endtask

    task automatic test_pipeline;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 32'h100 + i;
            apply(~i[0], a, 32'h1, 1'b1, 6'b000000, '{a + 32'h1, 1'b0, 1'b0, 1'b0});
            checks++;
            if (out_valid !== ~i[0]) begin
                errors++;
                $display("FAIL pipeline_valid[%0d]: out_valid=%b, want %b", i, out_valid, ~i[0]);
            end else if (!i[0]) begin
                last = exp_q.pop_front();
                got = '{S, Z, V, N};
                if (got !== last) begin
                    errors++;
                    $display("FAIL pipeline_data[%0d]: got %h, want %h", i, got, last);
                end
            end else begin
                got = '{S, Z, V, N};
                if (got !== last) begin
                    errors++;
                    $display("FAIL pipeline_hold[%0d]: got %h, want %h", i, got, last);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        apply(1'b1, 32'h1, 32'h1, 1'b1, 6'b000000, '{32'h2, 1'b0, 1'b0, 1'b0});
        exp_q.delete();
        rst_n = 1'b0;
        apply(1'b1, 32'h9, 32'h9, 1'b1, 6'b000000, '0);
        checks++;
        if ({S, Z, V, N, out_valid} !== 36'd0) begin
            errors++;
            $display("FAIL mid_reset: got S=%h Z=%b V=%b N=%b ov=%b, want all zero",
                     S, Z, V, N, out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [5:0]  funs [12] = '{6'b000000, 6'b000001, 6'b110011, 6'b110001, 6'b110101,
                                   6'b111101, 6'b111011, 6'b111111, 6'b110111, 6'b111001,
                                   6'b010000, 6'b100001};
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] a, b;
        logic        sg, vl;
        logic [5:0]  f;
        logic        pend;
        pend = 1'b0;
        for (int i = 0; i < 200; i++) begin
            a  = ($urandom_range(3) == 0) ? edges[$urandom_range(4)] : $urandom();
            b  = ($urandom_range(3) == 0) ? edges[$urandom_range(4)] : $urandom();
            if ($urandom_range(4) == 0) b = a;
            sg = $urandom_range(1) != 0;
            f  = funs[$urandom_range(11)];
            vl = (i < 100) ? 1'b1 : ($urandom_range(2) != 0);
            apply(vl, a, b, sg, f, model(a, b, sg, f));
            checks++;
            if (out_valid !== vl) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: out_valid=%b, want %b", i, out_valid, vl);
            end else if (vl) begin
                exp = exp_q.pop_front();
                got = '{S, Z, V, N};
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b[%0d] A=%h B=%h Sign=%b Fun=%b: got %h, want %h",
                             i, a, b, sg, f, got, exp);
                end
                last = exp;
                pend = 1'b1;
            end else if (pend) begin
                got = '{S, Z, V, N};
                if (got !== last) begin
                    errors++;
                    $display("FAIL b2b_hold[%0d]: got %h, want %h", i, got, last);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Sign = 1'b0; ALUFun = '0;
        test_reset();
        test_signed_cmp();
        test_inverted();
        test_unsigned();
        test_overflow_eq();
        test_pipeline();
        test_mid_reset();
        test_back_to_back();
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arith_cmp.md
Name: alu_arith_cmp

Overview:
Registered 32-bit arithmetic/compare slice of the course CPU ALU. It computes add or subtract with zero, overflow and negative flags, and turns those flags into a set/compare result. The ALUFun encoding is the standard 6-bit ALU function code used by the CPU decoder. The result and flags are registered, giving 1-cycle latency, and feed the datapath writeback/branch logic.

Parameters:
WIDTH, 32, operand/result width (all behaviour below stated for 32)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands/function valid this cycle
A  in  32  operand A
B  in  32  operand B
Sign  in  1  1 = signed (two's complement) interpretation, 0 = unsigned
ALUFun  in  6  function code
S  out  32  registered result
Z  out  1  registered zero flag
V  out  1  registered overflow flag
N  out  1  registered negative flag (true-sign)
out_valid  out  1  S/Z/V/N hold a result from the previous in_valid cycle

Behaviour:
Clocking and reset:
- One clock domain.
- Reset is synchronous and active-low: when rst_n=0 at a rising edge, S=0, Z=0, V=0, N=0 and out_valid=0. Reset overrides in_valid.
- Latency is 1 cycle.
- out_valid <= in_valid on every non-reset edge.
- S, Z, V and N load only when in_valid=1; otherwise they hold.
- No backpressure; a new operation may be accepted every cycle.

Function decode:
- ALUFun[5:4]=00: arithmetic. ALUFun[0]=0 is add (A+B); ALUFun[0]=1 is subtract (A-B). S = 32-bit wrapped result.
- ALUFun[5:4]=11: compare. The block always subtracts, regardless of ALUFun[0]. The operand used in place of B depends on ALUFun[3:1]:
  - 001 EQ: B used; S[0] = Z
  - 000 NEQ: B used; S[0] = ~Z
  - 010 LT: B used; S[0] = N
  - 110 LEZ: B forced to 0; S[0] = N|Z
  - 101 LTZ: B forced to 0; S[0] = N
  - 111 GTZ: B forced to 0; S[0] = ~N&~Z
  - 011 and 100: S[0] = 0
  - For all compare codes, S[31:1] = 0.
- ALUFun[5:4]=01 or 10 (logic/shift, handled by other slices): S = 0. Flags are still computed from A-B.

Flags (computed on the operation actually performed, with the effective B):
- Z = 1 when the 32-bit result is 0.
- Signed mode (Sign=1):
  - V = signed overflow. For add: operands have the same sign and the result sign differs. For sub: operands have different signs and the result sign differs from A.
  - N = result[31] XOR V, i.e. the sign of the mathematically exact result.
- Unsigned mode (Sign=0):
  - Add: V = carry-out, N = 0.
  - Sub: V = borrow (A<B unsigned), N = borrow.
- Consequence: LT performs an unsigned compare when Sign=0 and a signed compare when Sign=1.
- LEZ, LTZ and GTZ with Sign=0 treat A as unsigned, so LTZ is always 0.

Boundaries:
- Results wrap modulo 2^32.
- 0x80000000 - 1 with Sign=1 gives S=0x7FFFFFFF, V=1, N=1.
- Back-to-back in_valid: each result appears exactly one cycle after its inputs.
- Reset asserted mid-stream discards the in-flight result; out_valid=0 on the cycle after reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> S=0, Z=V=N=0, out_valid=0. Release reset -> the next result appears 1 cycle after rst_n=1.
- Signed compares, A=0x00000008, B=0xB38F0F83, Sign=1, one cycle each:
  - 000001 -> S=0x4C70F085, Z=0, V=0, N=0
  - 110011 -> S=0
  - 110001 -> S=1
  - 110101 -> S=0
  - 111101 -> S=0
  - 111011 -> S=0
  - 111111 -> S=1
- Inverted operands, A=0xFFFFFFF7, B=0x4C70F07C, Sign=1:
  - 000001 -> S=0xB38F0F7B, N=1
  - LT -> 1
  - LEZ -> 1
  - LTZ -> 1
  - GTZ -> 0
- Unsigned, A=0x00000008, B=0xB38F0F83, Sign=0:
  - LT (110101) -> S=1
  - sub -> V=1 (borrow)
  - LTZ -> 0
- Overflow and equality:
  - 0x7FFFFFFF + 0x00000001, ALUFun=000000, Sign=1 -> S=0x80000000, V=1, N=0
  - A=B=0x12345678, EQ -> S=1, Z=1
  - A=B=0x12345678, NEQ -> S=0
- Pipeline: alternate in_valid=1/0 across 4 cycles -> out_valid follows in_valid delayed by 1; S holds its value during idle cycles.
